// File: rtl/aclock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aclock_pkg
// Brief    : Shared limits, FSM state type and BCD helpers for alarm_clock_multi
// Revision : 1.0 - initial release
// ============================================================================
package aclock_pkg;

    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    // Binary 0..63 to {tens, units} BCD by repeated subtraction of ten.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic bcd_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclock_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : aclock_tick_gen
// Brief    : Divides clk down to a single-cycle one-second enable
// Revision : 1.0 - initial release
// ============================================================================
module aclock_tick_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running 0..CLK_DIV-1 counter; clear restarts the second phase.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_multi
// Brief    : 24h clock with NUM_ALARMS alarm slots, snooze, ring timeout and
//            optional 12h display
// Revision : 1.0 - initial release
// ============================================================================
module alarm_clock_multi
    import aclock_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    H_in1,
    input  logic [3:0]                    H_in0,
    input  logic [3:0]                    M_in1,
    input  logic [3:0]                    M_in0,
    input  logic                          LD_time,
    input  logic                          LD_alarm,
    input  logic [$clog2(NUM_ALARMS)-1:0] al_sel,
    input  logic [NUM_ALARMS-1:0]         AL_ON,
    input  logic                          STOP_al,
    input  logic                          SNOOZE,
    input  logic                          mode12,
    output logic                          Alarm,
    output logic [$clog2(NUM_ALARMS)-1:0] alarm_id,
    output logic                          pm,
    output logic                          tick_1s,
    output logic [1:0]                    H_out1,
    output logic [3:0]                    H_out0,
    output logic [3:0]                    M_out1,
    output logic [3:0]                    M_out0,
    output logic [3:0]                    S_out1,
    output logic [3:0]                    S_out0
);

    localparam int ID_W   = $clog2(NUM_ALARMS);
    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);

    logic              tick;
    logic [5:0]        hour, minute, second;
    logic [5:0]        ld_hour, ld_min;
    logic              ld_ok, ld_time_ok, ld_alarm_ok;
    logic              time_upd;
    logic [NUM_ALARMS-1:0] hit;
    logic              hit_any;
    logic [ID_W-1:0]   hit_id;
    logic              match;
    logic [ID_W-1:0]   match_id;
    state_t            state, next_state;
    logic [ID_W-1:0]   next_id;
    logic [RING_W-1:0] ring_cnt;
    logic [SNZ_W-1:0]  snz_cnt;
    logic [5:0]        disp_h;
    logic [7:0]        h_bcd, m_bcd, s_bcd;
    logic              unused_bits;

    // Load values; wrap-around of out-of-range inputs is harmless since
    // those loads are rejected by ld_ok.
    assign ld_hour = ({4'd0, H_in1} * 6'd10) + {2'd0, H_in0};
    assign ld_min  = ({2'd0, M_in1} * 6'd10) + {2'd0, M_in0};

    // With a valid units digit, tens <= 5 is exactly minute <= 59.
    assign ld_ok       = bcd_valid(H_in0) && bcd_valid(M_in0) &&
                         (M_in1 <= 4'd5) && (ld_hour <= MAX_HOUR);
    assign ld_time_ok  = LD_time && ld_ok;
    assign ld_alarm_ok = LD_alarm && ld_ok;

    // A rejected time load leaves the second phase untouched as well.
    aclock_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (ld_time_ok),
        .tick  (tick)
    );

    assign tick_1s = tick;

    // Time of day: a valid load wins over a coincident second tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
        end else if (ld_time_ok) begin
            hour   <= ld_hour;
            minute <= ld_min;
            second <= '0;
        end else if (tick) begin
            if (second == MAX_SEC) begin
                second <= '0;
                if (minute == MAX_MIN) begin
                    minute <= '0;
                    hour   <= (hour == MAX_HOUR) ? 6'd0 : hour + 6'd1;
                end else begin
                    minute <= minute + 6'd1;
                end
            end else begin
                second <= second + 6'd1;
            end
        end
    end

    // Remember that the time registers just changed so matching fires once.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_upd <= 1'b0;
        end else begin
            time_upd <= ld_time_ok || tick;
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
        logic [5:0] slot_h;
        logic [5:0] slot_m;
        logic       slot_v;

        // Alarm slot storage, written when selected by a valid load.
        always_ff @(posedge clk) begin
            if (reset) begin
                slot_h <= '0;
                slot_m <= '0;
                slot_v <= 1'b0;
            end else if (ld_alarm_ok && (al_sel == ID_W'(i))) begin
                slot_h <= ld_hour;
                slot_m <= ld_min;
                slot_v <= 1'b1;
            end
        end

        assign hit[i] = slot_v && AL_ON[i] && (hour == slot_h) &&
                        (minute == slot_m) && (second == 6'd0);
    end

    // Lowest-index matching slot wins.
    always_comb begin
        hit_any = |hit;
        hit_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_id = ID_W'(i);
            end
        end
    end

    // Single-cycle match event, raised only right after the time changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            match    <= 1'b0;
            match_id <= '0;
        end else begin
            match    <= time_upd && hit_any;
            match_id <= hit_id;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and next ringing slot.
    always_comb begin
        next_state = state;
        next_id    = alarm_id;
        case (state)
            IDLE: begin
                if (match) begin
                    next_state = RINGING;
                    next_id    = match_id;
                end
            end
            RINGING: begin
                if (STOP_al || !AL_ON[alarm_id]) begin
                    next_state = IDLE;
                end else if (SNOOZE) begin
                    next_state = SNOOZED;
                end else if (tick && (ring_cnt <= RING_W'(1))) begin
                    next_state = IDLE;
                end
            end
            SNOOZED: begin
                if (STOP_al || !AL_ON[alarm_id]) begin
                    next_state = IDLE;
                end else if (match && (match_id != alarm_id)) begin
                    next_state = RINGING;
                    next_id    = match_id;
                end else if (tick && (snz_cnt <= SNZ_W'(1))) begin
                    next_state = RINGING;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Ring and snooze second counters, reloaded on entry to their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            if ((next_state == RINGING) && (state != RINGING)) begin
                ring_cnt <= RING_W'(RING_SEC);
            end else if ((state == RINGING) && tick && (ring_cnt != '0)) begin
                ring_cnt <= ring_cnt - RING_W'(1);
            end
            if ((next_state == SNOOZED) && (state != SNOOZED)) begin
                snz_cnt <= SNZ_W'(SNOOZE_SEC);
            end else if ((state == SNOOZED) && tick && (snz_cnt != '0)) begin
                snz_cnt <= snz_cnt - SNZ_W'(1);
            end
        end
    end

    // Registered annunciator and slot id, aligned with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            Alarm    <= 1'b0;
            alarm_id <= '0;
        end else begin
            Alarm    <= (next_state == RINGING);
            alarm_id <= next_id;
        end
    end

    // Display hour: 12h mapping only affects the digits, never matching.
    always_comb begin
        disp_h = hour;
        if (mode12) begin
            if (hour == 6'd0) begin
                disp_h = 6'd12;
            end else if (hour > 6'd12) begin
                disp_h = hour - 6'd12;
            end
        end
    end

    assign pm     = mode12 && (hour >= 6'd12);
    assign h_bcd  = bin2bcd(disp_h);
    assign m_bcd  = bin2bcd(minute);
    assign s_bcd  = bin2bcd(second);
    assign H_out1 = h_bcd[5:4];
    assign H_out0 = h_bcd[3:0];
    assign M_out1 = m_bcd[7:4];
    assign M_out0 = m_bcd[3:0];
    assign S_out1 = s_bcd[7:4];
    assign S_out0 = s_bcd[3:0];

    // Hour tens never exceeds 2.
    assign unused_bits = ^h_bcd[7:6];

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_clock_multi
// Brief    : Scoreboard bench for alarm_clock_multi (alarm edge events)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] al_sel;
    logic [3:0] AL_ON;
    logic       STOP_al, SNOOZE, mode12;
    logic       Alarm;
    logic [1:0] alarm_id;
    logic       pm, tick_1s;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    typedef struct {
        int lvl;
        int id;
        int h;
        int m;
        int s;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cycle    = 0;
    int  L;

    alarm_clock_multi #(
        .CLK_DIV    (10),
        .NUM_ALARMS (4),
        .SNOOZE_SEC (300),
        .RING_SEC   (60)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .al_sel   (al_sel),
        .AL_ON    (AL_ON),
        .STOP_al  (STOP_al),
        .SNOOZE   (SNOOZE),
        .mode12   (mode12),
        .Alarm    (Alarm),
        .alarm_id (alarm_id),
        .pm       (pm),
        .tick_1s  (tick_1s),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int dh();
        return int'(H_out1) * 10 + int'(H_out0);
    endfunction
    function automatic int dm();
        return int'(M_out1) * 10 + int'(M_out0);
    endfunction
    function automatic int ds();
        return int'(S_out1) * 10 + int'(S_out0);
    endfunction

    task automatic chk_time(input string name, input int h, input int m, input int s);
        check({name, "_h"}, dh(), h);
        check({name, "_m"}, dm(), m);
        check({name, "_s"}, ds(), s);
    endtask

    task automatic push(input int lvl, input int id, input int h, input int m,
                        input int s, input int cyc);
        ev_t e;
        e.lvl = lvl; e.id = id; e.h = h; e.m = m; e.s = s; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic set_hm(input int h1, input int h0, input int m1, input int m0);
        H_in1 = 2'(h1);
        H_in0 = 4'(h0);
        M_in1 = 4'(m1);
        M_in0 = 4'(m0);
    endtask

    task automatic load(input int h1, input int h0, input int m1, input int m0);
        set_hm(h1, h0, m1, m0);
        LD_time = 1'b1;
        @(negedge clk);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input int sel, input int h1, input int h0,
                            input int m1, input int m0);
        set_hm(h1, h0, m1, m0);
        al_sel   = 2'(sel);
        LD_alarm = 1'b1;
        @(negedge clk);
        LD_alarm = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (cycle < c) @(negedge clk);
    endtask

    // Monitor: every Alarm edge must match the next expected event.
    logic prev_alarm = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (Alarm !== prev_alarm) begin
            prev_alarm = Alarm;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_alarm_edge: Alarm=%0b id=%0d at cycle %0d, no event expected",
                         Alarm, alarm_id, cycle);
            end else begin
                e = exp_q.pop_front();
                check("ev_level", int'(Alarm), e.lvl);
                check("ev_id", int'(alarm_id), e.id);
                check("ev_hour", dh(), e.h);
                check("ev_min", dm(), e.m);
                check("ev_sec", ds(), e.s);
                check("ev_cycle", cycle, e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; al_sel = 2'd0;
        AL_ON = 4'b0000; STOP_al = 1'b0; SNOOZE = 1'b0; mode12 = 1'b0;
        set_hm(0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        chk_time("rst", 0, 0, 0);
        check("rst_alarm", int'(Alarm), 0);
        check("rst_id", int'(alarm_id), 0);
        check("rst_tick", int'(tick_1s), 0);
        check("rst_pm", int'(pm), 0);
        reset = 1'b0;

        // Tick every 10 cycles, 10 s elapse
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("tick_pulse", int'(tick_1s), (k % 10 == 9) ? 1 : 0);
        end
        chk_time("run10s", 0, 0, 10);

        // 23:59 load, 12h view, midnight wrap
        load(2, 3, 5, 9);
        L = cycle;
        chk_time("ld2359", 23, 59, 0);
        mode12 = 1'b1; #1;
        check("m12_23_h", dh(), 11);
        check("m12_23_pm", int'(pm), 1);
        mode12 = 1'b0; #1;
        check("m24_23_pm", int'(pm), 0);
        run_until(L + 600);
        chk_time("wrap", 0, 0, 0);
        mode12 = 1'b1; #1;
        check("m12_00_h", dh(), 12);
        check("m12_00_pm", int'(pm), 0);
        mode12 = 1'b0; #1;

        // Rejected loads leave the time alone
        load(0, 9, 9, 7);
        chk_time("rej_min97", 0, 0, 0);
        load(0, 1, 0, 10);
        chk_time("rej_digit", 0, 0, 0);
        load(2, 4, 0, 0);
        chk_time("rej_hour24", 0, 0, 0);

        // Noon and 13h in both display modes
        load(1, 2, 0, 0);
        mode12 = 1'b1; #1;
        check("m12_12_h", dh(), 12);
        check("m12_12_pm", int'(pm), 1);
        mode12 = 1'b0; #1;
        load(1, 3, 0, 5);
        chk_time("ld1305", 13, 5, 0);
        mode12 = 1'b1; #1;
        check("m12_13_h", dh(), 1);
        check("m12_13_m", dm(), 5);
        check("m12_13_pm", int'(pm), 1);
        mode12 = 1'b0; #1;

        // Two slots at 07:30, lowest index wins; auto-stop after 60 s
        ld_alarm(1, 0, 7, 3, 0);
        ld_alarm(2, 0, 7, 3, 0);
        AL_ON = 4'b0110;
        load(0, 7, 2, 9);
        L = cycle;
        chk_time("ld0729", 7, 29, 0);
        push(1, 1, 7, 30, 0, L + 602);
        push(0, 1, 7, 31, 0, L + 1200);
        run_until(L + 1210);

        // Snooze, re-ring after 300 s, then STOP together with SNOOZE
        load(0, 7, 3, 0);
        L = cycle;
        push(1, 1, 7, 30, 0, L + 2);
        run_until(L + 5);
        push(0, 1, 7, 30, 0, L + 6);
        SNOOZE = 1'b1;
        @(negedge clk);
        SNOOZE = 1'b0;
        push(1, 1, 7, 35, 0, L + 3000);
        run_until(L + 3003);
        push(0, 1, 7, 35, 0, L + 3004);
        STOP_al = 1'b1; SNOOZE = 1'b1;
        @(negedge clk);
        STOP_al = 1'b0; SNOOZE = 1'b0;
        repeat (10) @(negedge clk);
        check("stop_beats_snooze", int'(Alarm), 0);

        // Dropping AL_ON of the ringing slot stops it
        load(0, 7, 3, 0);
        L = cycle;
        push(1, 1, 7, 30, 0, L + 2);
        run_until(L + 4);
        push(0, 1, 7, 30, 0, L + 5);
        AL_ON = 4'b0100;
        @(negedge clk);
        AL_ON = 4'b0110;

        // While snoozed, another slot's match takes over with its id
        ld_alarm(0, 0, 7, 3, 1);
        AL_ON = 4'b0111;
        load(0, 7, 3, 0);
        L = cycle;
        push(1, 1, 7, 30, 0, L + 2);
        run_until(L + 5);
        push(0, 1, 7, 30, 0, L + 6);
        SNOOZE = 1'b1;
        @(negedge clk);
        SNOOZE = 1'b0;
        push(1, 0, 7, 31, 0, L + 602);
        run_until(L + 605);
        push(0, 0, 7, 31, 0, L + 606);
        STOP_al = 1'b1;
        @(negedge clk);
        STOP_al = 1'b0;

        // Reset while ringing
        load(0, 7, 3, 0);
        L = cycle;
        push(1, 1, 7, 30, 0, L + 2);
        run_until(L + 4);
        push(0, 0, 0, 0, 0, L + 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_time("rst_ring", 0, 0, 0);
        check("rst_ring_alarm", int'(Alarm), 0);
        check("rst_ring_id", int'(alarm_id), 0);

        // Slot0 = 00:00 loaded without a new matching minute: silent
        AL_ON = 4'b0111;
        ld_alarm(0, 0, 0, 0, 0);
        repeat (25) @(negedge clk);
        check("no_fire_slot0", int'(Alarm), 0);
        // Slots 1/2 were cleared by reset: 07:30 stays silent
        load(0, 7, 3, 0);
        repeat (25) @(negedge clk);
        check("no_fire_cleared", int'(Alarm), 0);

        // LD_time and LD_alarm in the same cycle both apply
        AL_ON = 4'b0110;
        set_hm(0, 0, 0, 0);
        al_sel = 2'd1;
        LD_time = 1'b1; LD_alarm = 1'b1;
        @(negedge clk);
        LD_time = 1'b0; LD_alarm = 1'b0;
        L = cycle;
        push(1, 1, 0, 0, 0, L + 2);
        run_until(L + 4);
        push(0, 1, 0, 0, 0, L + 5);
        STOP_al = 1'b1;
        @(negedge clk);
        STOP_al = 1'b0;
        repeat (5) @(negedge clk);

        check("events_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised next-generation alarm clock. Keeps a 24-hour HH:MM:SS time, driven by a single-cycle 1-second tick enable rather than a derived clock. Holds NUM_ALARMS independently loadable alarm slots and adds snooze, an auto-timeout on ringing, and an optional 12-hour display mode. Sits in the same clock/display subsystem and drives the BCD display digits plus the alarm annunciator.

Parameters:
CLK_DIV, 10, clk cycles per second; must be ≥2.
NUM_ALARMS, 4, number of alarm slots; must be ≥2.
SNOOZE_SEC, 300, snooze length in seconds.
RING_SEC, 60, seconds the alarm rings before auto-stop.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
H_in1  in  2  BCD hour tens (load value, 24h)
H_in0  in  4  BCD hour units
M_in1  in  4  BCD minute tens
M_in0  in  4  BCD minute units
LD_time  in  1  load time from H_in*/M_in*
LD_alarm  in  1  load alarm slot al_sel from H_in*/M_in*
al_sel  in  $clog2(NUM_ALARMS)  alarm slot index
AL_ON  in  NUM_ALARMS  per-slot alarm enable
STOP_al  in  1  stop ringing/snooze
SNOOZE  in  1  snooze request
mode12  in  1  1 = 12-hour display
Alarm  out  1  annunciator, registered
alarm_id  out  $clog2(NUM_ALARMS)  slot that fired
pm  out  1  PM indicator; 0 when mode12=0
tick_1s  out  1  one-cycle second pulse
H_out1, H_out0, M_out1, M_out0, S_out1, S_out0  out  2,4,4,4,4,4  BCD display digits

Behaviour:
- Clocking and reset: everything on posedge clk. reset=1 overrides all other inputs.
- Reset values: time 00:00:00; divider 0; all slot valid bits 0 and slot times 00:00; state IDLE; Alarm=0; alarm_id=0; tick_1s=0.
- Divider: counts 0..CLK_DIV-1. tick_1s=1 for exactly the cycle where count==CLK_DIV-1.
- Time counters: binary hour 0–23, minute 0–59, second 0–59.
  - On tick: second+1; 59→0 carries to minute; 59→0 carries to hour; 23→0 wraps.
  - 23:59:59 + tick → 00:00:00.
- LD_time:
  - Loads hour = 10*H_in1 + H_in0, minute likewise, second=0, divider=0.
  - Takes effect next cycle and beats a coincident tick.
  - Rejected (no state change) if any BCD digit >9, hour >23, or minute >59.
- LD_alarm: writes slot al_sel (HH:MM), sets its valid bit. Same validity check as LD_time.
- LD_time and LD_alarm in the same cycle: both apply.
- Match event: a single-cycle flag, registered in the cycle after the time registers change (by tick or LD_time), when time == slot HH:MM:00, valid=1 and AL_ON[i]=1. If several slots match, the lowest index wins.
- State machine states: IDLE, RINGING, SNOOZED.
  - IDLE: on match → RINGING, latch alarm_id, ring counter = RING_SEC.
  - RINGING: Alarm=1; ring counter decrements on tick; reaching 0 → IDLE.
  - RINGING: STOP_al → IDLE. SNOOZE → SNOOZED, snooze counter = SNOOZE_SEC. STOP_al beats SNOOZE in the same cycle.
  - RINGING: new matches are ignored.
  - SNOOZED: Alarm=0; snooze counter decrements on tick; reaching 0 → RINGING with the same alarm_id and ring counter reloaded.
  - SNOOZED: STOP_al → IDLE. A new match from another slot → RINGING with the new id.
  - RINGING or SNOOZED: AL_ON[alarm_id] falling → IDLE.
- Alarm output: registered; Alarm = (state==RINGING). Alarm rises 2 cycles after the display shows HH:MM:00.
- Display: combinational binary→BCD from the time registers.
  - mode12=1: hour 0→12, 13–23→h-12, 1–12 unchanged; pm=(hour≥12).
  - Alarm matching always uses the 24h registers.

Decomposition:
- Package aclock_pkg holds: MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59; the state enum {IDLE, RINGING, SNOOZED}; function bin2bcd(6-bit) returning tens/units; function bcd_valid.
- One sub-module: aclock_tick_gen (parameter CLK_DIV; ports clk, reset, clear, tick). clear is driven by LD_time.

Test Plan:
- Reset, run 10 s at CLK_DIV=10 → tick every 10 cycles; display 00:00:10.
- LD_time 23:59, run 60 ticks → 00:00:00 wrap; mode12=1 → H_out=12, pm=0.
- LD_time H_in0=9, M_in1=7 (minute 97) → rejected, time unchanged. LD_time hour 24 → rejected.
- Slot1=07:30 and slot2=07:30, both AL_ON, LD_time 07:29, 60 ticks → Alarm=1, alarm_id=1; RING_SEC ticks later Alarm=0.
- Ringing: SNOOZE → Alarm=0; after SNOOZE_SEC ticks Alarm=1 again with the same id. STOP_al together with SNOOZE → IDLE, Alarm stays 0.
- Ringing: assert reset → next cycle Alarm=0, time 00:00:00, all slots invalid; reload 00:00 in slot0 → no fire without a new matching minute.
